// File: rtl/pulse_receiver_decoder.sv
// Pulse-width receiver: glitch filter, prescaled segment timer, short/long symbol
// decoder and 16-symbol word packer with a valid/ready output register.
module pulse_receiver_decoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        sig_in,
  input  logic        invert_input,
  input  logic        idle_level,
  input  logic [3:0]  prescaler,
  input  logic [3:0]  glitch_len,
  input  logic [7:0]  threshold,
  input  logic [7:0]  timeout,
  output logic [31:0] word_out,
  output logic [4:0]  word_syms,
  output logic        word_valid,
  input  logic        word_ready,
  output logic        frame_done,
  output logic        overflow,
  output logic        busy
);

  typedef enum logic {IDLE, MEASURE} state_t;

  state_t      state, state_next;
  logic        raw, filt, filt_edge, tick, timeout_hit, emit;
  logic [3:0]  glitch_cnt;
  logic [14:0] ps_cnt, ps_max;
  logic [7:0]  dur, dur_inc;
  logic        sym_valid;
  logic [1:0]  sym;
  logic [31:0] pack;
  logic [4:0]  pack_cnt;
  logic        xfer, drop;
  logic [31:0] xfer_word;
  logic [4:0]  xfer_syms;

  assign raw       = sig_in ^ invert_input;
  assign filt_edge = (raw != filt) && (glitch_cnt == glitch_len);
  assign ps_max    = ~(15'h7fff << prescaler);
  assign tick      = (ps_cnt == ps_max);
  // Duration of the segment as of this clock, counting a tick that lands on the edge.
  assign dur_inc   = (tick && dur != 8'hff) ? dur + 8'd1 : dur;
  assign timeout_hit = (state == MEASURE) && (filt == idle_level) &&
                       (timeout != 8'd0) && (dur == timeout);
  assign emit      = (state == MEASURE) && filt_edge && !timeout_hit;

  always_ff @(posedge clk) begin
    if (rst || !en) state <= IDLE;
    else            state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (filt_edge && filt == idle_level) state_next = MEASURE;
      MEASURE: if (timeout_hit)                     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == MEASURE);
  end

  // A symbol emitted at an edge is packed one clock later, so a full word
  // includes the pending symbol in its top slot.
  always_comb begin
    xfer      = 1'b0;
    xfer_word = pack;
    xfer_syms = pack_cnt;
    if (sym_valid && pack_cnt == 5'd15) begin
      xfer            = 1'b1;
      xfer_word[31:30] = sym;
      xfer_syms       = 5'd16;
    end else if (timeout_hit && pack_cnt != 5'd0) begin
      xfer = 1'b1;
    end
  end

  assign drop = xfer && word_valid && !word_ready;

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      filt       <= idle_level;
      glitch_cnt <= '0;
      ps_cnt     <= '0;
      dur        <= '0;
      sym_valid  <= 1'b0;
      sym        <= '0;
      pack       <= '0;
      pack_cnt   <= '0;
      word_out   <= '0;
      word_syms  <= '0;
      word_valid <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      if (raw == filt) begin
        glitch_cnt <= '0;
      end else if (glitch_cnt == glitch_len) begin
        filt       <= ~filt;
        glitch_cnt <= '0;
      end else begin
        glitch_cnt <= glitch_cnt + 4'd1;
      end

      if (filt_edge) begin
        ps_cnt <= '0;
        dur    <= '0;
      end else begin
        ps_cnt <= tick ? '0 : ps_cnt + 15'd1;
        dur    <= dur_inc;
      end

      sym_valid <= emit;
      sym       <= {filt, (dur_inc > threshold)};

      if (xfer || timeout_hit) begin
        pack     <= '0;
        pack_cnt <= '0;
      end else if (sym_valid) begin
        pack[{pack_cnt[3:0], 1'b0} +: 2] <= sym;
        pack_cnt <= pack_cnt + 5'd1;
      end

      if (xfer && !drop) begin
        word_out   <= xfer_word;
        word_syms  <= xfer_syms;
        word_valid <= 1'b1;
      end else if (word_valid && word_ready) begin
        word_valid <= 1'b0;
      end

      frame_done <= timeout_hit;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)              overflow <= 1'b0;
    else if (en && drop)  overflow <= 1'b1;
  end

endmodule

// File: doc/pulse_receiver_decoder.md
PULSE_RECEIVER_DECODER -- requirements
Module: pulse_receiver_decoder

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have ports: rst  in  1  reset; synchronous, active-high.
REQ-003 SHALL have ports: en  in  1  receiver enable; low clears all state except overflow.
REQ-004 SHALL have ports: sig_in  in  1  pulse input, already synchronized to clk.
REQ-005 SHALL have ports: invert_input  in  1  XORed with sig_in before filtering.
REQ-006 SHALL have ports: idle_level  in  1  line level meaning "no pulse".
REQ-007 SHALL have ports: prescaler  in  4  one tick per 2^prescaler clocks.
REQ-008 SHALL have ports: glitch_len  in  4  filter depth; a level change is accepted after glitch_len+1 consecutive differing clocks.
REQ-009 SHALL have ports: threshold  in  8  segment duration in ticks; duration > threshold gives a long symbol.
REQ-010 SHALL have ports: timeout  in  8  idle ticks that end a frame; 0 disables end-of-frame.
REQ-011 SHALL have ports: word_out  out  32  packed symbols, 2 bits each, symbol 0 at [1:0].
REQ-012 SHALL have ports: word_syms  out  5  valid symbols in word_out (1..16).
REQ-013 SHALL have ports: word_valid  out  1 / word_ready  in  1  output handshake.
REQ-014 SHALL have ports: frame_done  out  1  one-clock pulse at end of frame.
REQ-015 SHALL have ports: overflow  out  1  sticky; cleared only by rst.
REQ-016 SHALL have ports: busy  out  1  high while in MEASURE.

Function
REQ-017 Symbol encoding SHALL be {level, long}: level = filtered level of the segment; long = (duration > threshold). 0=low short, 1=low long, 2=high short, 3=high long.
REQ-018 Filter: a 4-bit counter SHALL count clocks where raw != filt and clear when raw == filt; at count == glitch_len, filt toggles and the counter clears. On entry to enable, filt = idle_level.
REQ-019 Tick: a 15-bit prescale counter SHALL emit a tick when it equals 2^prescaler-1, then wrap to 0; it clears on every filt edge.
REQ-020 Duration: an 8-bit counter SHALL increment on each tick and saturate at 255; it clears on every filt edge.
REQ-021 FSM states SHALL be IDLE and MEASURE. IDLE -> MEASURE on the first filt edge away from idle_level, with no symbol emitted.
REQ-022 In MEASURE, each filt edge SHALL emit one symbol for the segment just ended, computed from the pre-clear duration; it is packed on the clock after the edge.
REQ-023 In MEASURE, with filt == idle_level and timeout != 0, reaching duration == timeout SHALL: emit no symbol for the trailing idle segment, flush any partial word, pulse frame_done, and return to IDLE.
REQ-024 Packing: symbols SHALL go into a 32-bit shift/pack register at slot (index mod 16). After 16 symbols, or on a flush with at least one symbol, the pack register SHALL transfer to the output register with unused bits zero and word_syms set.
REQ-025 word_valid SHALL be asserted on the clock after the transfer. word_out and word_syms SHALL hold stable until a clock with word_valid && word_ready, after which word_valid drops (unless a new transfer occurs in that same cycle).
REQ-026 Overflow: on a transfer while word_valid=1 and word_ready=0, the new word SHALL be dropped, overflow SHALL be set, and the pack register SHALL still clear.
REQ-027 A transfer coinciding with acceptance (word_ready=1) SHALL load the new word with no overflow.
REQ-028 A flush with zero symbols SHALL produce no word, but frame_done SHALL still pulse.
REQ-029 Parameter inputs SHALL be sampled live; changing them mid-frame is legal, and their effect on the current segment is undefined.

Reset
REQ-030 On rst, or while en=0: FSM=IDLE, all counters 0, pack register 0, word_out=0, word_syms=0, word_valid=0, frame_done=0, busy=0, filt=idle_level. overflow clears on rst only.
REQ-031 Dropping en mid-frame SHALL discard the partial word and any pending output word without pulsing frame_done.

Verification
REQ-032 prescaler=0, glitch_len=0, threshold=4, timeout=10, idle_level=0; pulses high 3, low 8, high 6, then idle -> word_valid with word_out[5:0]=0b11_01_10, word_syms=3, one frame_done.
REQ-033 glitch_len=3, 2-clock high spikes on an idle line -> FSM stays IDLE, no word, busy=0.
REQ-034 Send 16 alternating short segments with word_ready=1 -> one word, word_syms=16, pattern 0x22222222 (high-short first), then a flush of the 17th-and-later symbols on timeout.
REQ-035 Send 33 symbols with word_ready held 0 -> first word held unchanged, overflow=1, second word dropped.
REQ-036 prescaler=2, segment of 12 clocks, threshold=2 -> duration 3, long=1; segment of 8 clocks -> long=0.
REQ-037 Deassert en mid-frame after 5 symbols -> word_valid=0, busy=0, no frame_done; re-enable and receive a fresh frame correctly.
